// File: rtl/serial_sub_compare_ctrl.sv
// Serial wide subtract/compare: one shared 4-bit nibble subtractor is stepped
// LSB nibble first. The borrow is chained between nibbles through a register.
// The result flags are produced when the final nibble retires.

module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub_compare_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 borrow,
  output logic                 a_gt_b,
  output logic                 a_eq_b,
  output logic                 a_lt_b
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_reg, b_reg, diff_nxt;
  logic           borrow_reg;
  logic [KW-1:0]  k;
  logic [3:0]     nib_a, nib_b, nib_d;
  logic [4:0]     chain;
  logic           last, load;

  assign last = (k == KW'(NIBBLES - 1));
  // start is only honoured when no operation is in flight
  assign load = start && (state == IDLE || state == DONE);

  // Pick the current nibble of each operand; a constant-index mux keeps
  // select widths exact for any NIBBLES.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++)
      if (k == KW'(i)) begin
        nib_a = a_reg[4*i +: 4];
        nib_b = b_reg[4*i +: 4];
      end
  end

  // Shared nibble stage: ripple of four 1-bit subtractors, borrow-in from register
  assign chain[0] = borrow_reg;
  for (genvar g = 0; g < 4; g++) begin : g_fs
    full_subtractor_1bit u_fs (
      .a    (nib_a[g]),
      .b    (nib_b[g]),
      .bin  (chain[g]),
      .d    (nib_d[g]),
      .bout (chain[g+1])
    );
  end

  // diff with the current nibble merged in; used for write-back and the zero test
  always_comb begin
    diff_nxt = diff;
    for (int i = 0; i < NIBBLES; i++)
      if (k == KW'(i)) diff_nxt[4*i +: 4] = nib_d;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, per-nibble write-back, flags on the last nibble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      k          <= '0;
      diff       <= '0;
      borrow     <= 1'b0;
      a_gt_b     <= 1'b0;
      a_eq_b     <= 1'b0;
      a_lt_b     <= 1'b0;
    end else if (load) begin
      a_reg      <= a;
      b_reg      <= b;
      borrow_reg <= 1'b0;
      k          <= '0;
    end else if (state == RUN) begin
      diff       <= diff_nxt;
      borrow_reg <= chain[4];
      k          <= k + 1'b1;
      if (last) begin
        borrow <= chain[4];
        a_lt_b <= chain[4];
        a_eq_b <= (diff_nxt == '0) & ~chain[4];
        a_gt_b <= ~chain[4] & (diff_nxt != '0);
      end
    end
  end
endmodule

// File: doc/serial_sub_compare_ctrl.md
# serial_sub_compare_ctrl

Sequencing controller that computes a wide subtraction and magnitude compare by running one shared 4-bit nibble subtractor once per clock, LSB nibble first. The stored borrow is chained between nibbles. The nibble stage is a ripple of four `full_subtractor_1bit` cells whose borrow-in comes from the controller's borrow register. The block sits between operand sources and comparator/decision logic, trading latency for a single narrow datapath.

## Interface
- `NIBBLES`, default 4: number of 4-bit nibbles per operand. Operand width `W = 4*NIBBLES`. Legal range is 1..16.
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a new operation. Sampled only in IDLE or DONE.
- `a`  in  W: minuend. Captured on the accepted `start` edge.
- `b`  in  W: subtrahend. Captured on the accepted `start` edge.
- `busy`  out  1: high while nibbles are being processed (RUN).
- `done`  out  1: one-cycle pulse when the result becomes valid.
- `diff`  out  W: `a - b` mod 2^W.
- `borrow`  out  1: final borrow out; 1 means a < b (unsigned).
- `a_gt_b`  out  1: result flag, a > b.
- `a_eq_b`  out  1: result flag, a == b.
- `a_lt_b`  out  1: result flag, a < b.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 captures `a`/`b` into operand registers, clears the borrow register and nibble counter `k`, and moves to RUN.
  - `start`=0 stays in IDLE.
- **RUN**, each cycle:
  - Nibble stage computes `a[4k+3:4k] - b[4k+3:4k] - borrow_reg`.
  - The 4-bit difference is written to `diff[4k+3:4k]`, and the stage borrow-out is written to `borrow_reg`.
  - `k` increments.
  - After nibble `NIBBLES-1` is processed, go to DONE.
- **DONE**, one cycle:
  - `done`=1.
  - Flags update from the final result: `a_lt_b = borrow_reg`, `a_eq_b = (diff == 0) & ~borrow_reg`, `a_gt_b = ~a_lt_b & ~a_eq_b`.
  - Exactly one flag is high.
  - If `start`=1 in this cycle, new operands are captured and the state goes directly to RUN. Otherwise the state goes to IDLE.
- `diff`, `borrow` and the flags hold their values from DONE until the next DONE.
  - `diff` nibbles update progressively during RUN; they are valid only when `done` is high or later.
  - Flags and `borrow` change only on entry to DONE.
- `start` in RUN is ignored, with no queueing. Operand inputs may change freely after capture.
- Arithmetic is unsigned throughout, wrap-around modulo 2^W. `NIBBLES`=1 degenerates to a single RUN cycle.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0, `a_gt_b`=0, `a_eq_b`=0, `a_lt_b`=0, `k`=0.
- Reset asserted mid-RUN aborts immediately. There is no `done` pulse, and the partial `diff` is cleared to 0.
- Latency, with the `start` edge at cycle 0:
  - `busy`=1 in cycles 1..NIBBLES.
  - `done`=1 in cycle NIBBLES+1.
  - Results are valid from cycle NIBBLES+1.
- Back-to-back throughput: one result per NIBBLES+1 cycles when `start` is held high.
- `busy` and `done` are never high together.

## Test plan
- **Reset, then equal operands:** NIBBLES=4, `a`=0x1234, `b`=0x1234 → `done` in cycle 5, `diff`=0x0000, `borrow`=0, `a_eq_b`=1.
- **Underflow:** `a`=0x0000, `b`=0x0001 → `diff`=0xFFFF, `borrow`=1, `a_lt_b`=1.
- **Borrow ripples across nibbles:**
  - `a`=0x1000, `b`=0x0001 → `diff`=0x0FFF, `a_gt_b`=1.
  - `a`=0xF000, `b`=0x0FFF → `diff`=0xE001, `a_gt_b`=1.
- **Ignored start and operand changes during RUN:** start with 0x0005 − 0x0003, pulse `start` with 0x0001/0x0009 in cycle 2, and change `a`/`b` during RUN → result is `diff`=0x0002, `a_gt_b`=1, with exactly one `done` pulse.
- **Back-to-back:** `start` held high through DONE with the second operands 0x0003/0x0005 → second `done` exactly 5 cycles after the first, `diff`=0xFFFE, `a_lt_b`=1.
- **Reset mid-operation:** assert `rst` in cycle 3 → all outputs 0 asynchronously and no `done`. A subsequent start with 0x00FF/0x00FF gives `a_eq_b`=1.
